letreiro_sequenciador: RTL
==========================

# letreiro_sequenciador

Scrolling-message source for the marquee display. It holds the fixed message "gabriel " as 3-bit symbol codes and slides a DIGITS-wide window across it once per prescaled step. Each digit's output is the 3-bit code the per-digit 7-segment decoder consumes. Codes: 0 space, 1 g, 2 a, 3 b, 4 r, 5 i, 6 e, 7 l.

## Interface
Parameters:
- DIGITS, 4, number of display digits driven (legal 1..8)
- DIV, 50000000, clock cycles per scroll step (legal >= 1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  one-cycle pulse: (re)start scrolling from position 0
- stop  in  1  one-cycle pulse: return to blank
- pause  in  1  level: freeze prescaler and position while high
- dir  in  1  0 = text moves left (pos increments), 1 = text moves right (pos decrements)
- codes  out  3*DIGITS  digit k (k=0 leftmost) at bits [3k+2:3k]
- pos  out  3  current window start index into message
- step  out  1  one-cycle pulse when pos advances
- busy  out  1  high in SCROLL state

## Operation
- Message ROM msg[0..7] = 1,2,3,4,5,6,7,0 ("gabriel "), circular.
- States: BLANK, SCROLL.
- BLANK: codes all 0 (all spaces), busy=0, cnt=0, pos=0. start -> SCROLL with pos=0, cnt=0.
- SCROLL: codes digit k = msg[(pos+k) mod 8]; busy=1.
  - pause=0: cnt increments; when cnt==DIV-1, cnt<=0, pos<=pos+1 mod 8 (dir=0) or pos-1 mod 8 (dir=1, 0 wraps to 7), step<=1 for that one cycle.
  - pause=1: cnt, pos held; step=0.
  - start in SCROLL: pos<=0, cnt<=0, no step that cycle (restart).
  - stop: -> BLANK, pos<=0, cnt<=0.
- Priority per edge: rst_n low > stop > start > prescaler advance.
- dir is sampled on the advancing edge only; changing dir mid-count does not reset cnt.
- cnt width = clog2(DIV) (min 1); DIV=1 means pos advances every cycle in SCROLL.

## Timing
- Reset (rst_n low at an edge): state BLANK, pos=0, cnt=0, step=0, busy=0, codes all 0.
- state, pos, cnt, step are registers; codes and busy are combinational from state and pos only (no combinational path from any input to any output).
- start sampled at edge n: busy=1 and codes = g a b r (DIGITS=4) after edge n.
- First step: asserted after edge n+DIV (pause low throughout); subsequent steps every DIV cycles; pos and codes change in the same cycle step is high.
- pause high for P cycles delays every later step by exactly P cycles.
- stop and start in the same cycle: stop wins, BLANK.
- rst_n low mid-scroll: all outputs to reset values after that edge, regardless of other inputs.

## Test plan
- Reset: hold rst_n=0 two cycles with start=1 -> after release codes=0, pos=0, busy=0, step=0.
- Left scroll (DIV=4, DIGITS=4, dir=0): start pulse -> codes 1,2,3,4; step every 4 cycles; pos 1 -> codes 2,3,4,5; after 8 steps pos=0 again, codes 1,2,3,4; at pos=5 codes 6,7,0,1.
- Right scroll wrap: start then dir=1 -> first step pos=7, codes 0,1,2,3; next pos=6, codes 7,0,1,2.
- Pause: after start, pause high 10 cycles starting at cnt=2 -> next step arrives 2+10 cycles later, pos unchanged during pause.
- Control conflicts: start and stop same cycle in SCROLL -> BLANK, codes 0; start in SCROLL at pos=3 -> pos=0, next step 4 cycles later.
- DIV=1: start -> step high every cycle, pos 1,2,...,7,0 on consecutive cycles.

Source files
------------

// File: rtl/letreiro_sequenciador.sv
// Scrolling-message source for the marquee: slides a DIGITS-wide window over "gabriel "
// and emits one 3-bit symbol code per digit for the 7-segment decoders.
module letreiro_sequenciador #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  dir,
    output logic [3*DIGITS-1:0]   codes,
    output logic [2:0]            pos,
    output logic                  step,
    output logic                  busy
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic {BLANK, SCROLL} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       pos_q;
    logic             step_q;

    // Message ROM: "gabriel " where each letter's code is simply its index + 1
    function automatic logic [2:0] msg_code(input logic [2:0] idx);
        case (idx)
            3'd0:    msg_code = 3'd1;
            3'd1:    msg_code = 3'd2;
            3'd2:    msg_code = 3'd3;
            3'd3:    msg_code = 3'd4;
            3'd4:    msg_code = 3'd5;
            3'd5:    msg_code = 3'd6;
            3'd6:    msg_code = 3'd7;
            default: msg_code = 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (stop) begin
                state_q <= BLANK;
                cnt_q   <= '0;
                pos_q   <= '0;
            end else if (start) begin
                state_q <= SCROLL;
                cnt_q   <= '0;
                pos_q   <= '0;
            end else if (state_q == SCROLL && !pause) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q  <= '0;
                    pos_q  <= dir ? pos_q - 3'd1 : pos_q + 3'd1;
                    step_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Outputs depend only on registered state, never directly on inputs
    always_comb begin
        codes = '0;
        if (state_q == SCROLL) begin
            for (int k = 0; k < DIGITS; k++) begin
                codes[3*k +: 3] = msg_code(pos_q + 3'(k));
            end
        end
    end

    assign busy = (state_q == SCROLL);
    assign pos  = pos_q;
    assign step = step_q;

endmodule
